load_store_unit: RTL and testbench

- Sits directly downstream of the ALU: takes the ALU result as the effective address, plus rs2 data and funct3, and performs one data-memory load or store.
- Handles byte-lane selection, write masks and load sign/zero extension.
- Holds the request until the memory acknowledges it, and reports completion, misalignment and illegal width.
- Gives the core a clean, multi-cycle-tolerant data-memory path.

---
 rtl/core_pkg.sv | 47 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared funct3 encodings, LSU state enum, lane masks and
//               access-legality helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int OFF_W = 2;

    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H_LO = 4'b0011;
    localparam logic [3:0] MASK_H_HI = 4'b1100;
    localparam logic [3:0] MASK_W    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // Unsigned widths only make sense for loads.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return store;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane steering: store mask and replicated
//               write data, load lane extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_off,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_rdata,
    output logic [3:0]       o_mask,
    output logic [31:0]      o_wdata,
    output logic [31:0]      o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_mask  = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_mask  = MASK_B << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
            end
            F3_H, F3_HU: begin
                o_mask  = i_off[1] ? MASK_H_HI : MASK_H_LO;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
            end
            F3_W: begin
                o_mask = MASK_W;
            end
            default: begin
                o_mask = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding data-memory load/store with lane steering,
//               handshake hold until i_dmem_ready and fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_store,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_ready,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_misaligned,
    output logic                  o_illegal,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic                  o_dmem_ren,
    output logic                  o_dmem_wen,
    output logic [31:0]           o_dmem_wdata,
    output logic [3:0]            o_dmem_mask,
    input  logic [31:0]           i_dmem_rdata,
    input  logic                  i_dmem_ready
);

    lsu_state_t            r_state;
    logic                  r_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_misaligned;
    logic                  r_illegal;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_access;
    logic [3:0]            w_mask;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;

    assign w_illegal    = f3_illegal(i_store, i_funct3);
    assign w_misaligned = f3_misaligned(i_funct3, i_addr[OFF_W-1:0]);
    assign w_access     = (r_state == ST_ACCESS);

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[OFF_W-1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (i_dmem_rdata),
        .o_mask   (w_mask),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= 32'b0;
            r_rdata      <= 32'b0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_store      <= i_store;
                        r_funct3     <= i_funct3;
                        r_addr       <= i_addr;
                        r_wdata      <= i_wdata;
                        r_rdata      <= 32'b0;
                        r_illegal    <= w_illegal;
                        // Illegal wins: an unsupported width has no alignment rule.
                        r_misaligned <= w_misaligned & ~w_illegal;
                        r_state      <= (w_illegal | w_misaligned) ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (i_dmem_ready) begin
                        if (!r_store) begin
                            r_rdata <= w_rdata;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready      = (r_state == ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_rdata      = r_rdata;
    assign o_misaligned = r_misaligned;
    assign o_illegal    = r_illegal;
    assign o_dmem_addr  = {r_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign o_dmem_ren   = w_access & ~r_store;
    assign o_dmem_wen   = w_access & r_store;
    assign o_dmem_mask  = w_access ? w_mask : 4'b0000;
    assign o_dmem_wdata = w_access ? w_wdata : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed scoreboard bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        illegal;
    logic [31:0] dmem_addr;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_store      (store),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_ready      (ready),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_misaligned (misaligned),
        .o_illegal    (illegal),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_ren   (dmem_ren),
        .o_dmem_wen   (dmem_wen),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_mask  (dmem_mask),
        .i_dmem_rdata (dmem_rdata),
        .i_dmem_ready (dmem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pops one expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                chk("done_illegal", {31'b0, illegal}, {31'b0, e.ill});
                if (e.chk_rdata) chk("done_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mem, input int delay,
                       input logic [3:0] emask, input logic [31:0] ewd,
                       input logic fault, input exp_t e, input logic poke);
        @(negedge clk);
        chk("ready_before", {31'b0, ready}, 32'd1);
        req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
        q.push_back(e);
        @(negedge clk);
        req = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        if (!fault) begin
            for (int k = 0; k <= delay; k++) begin
                chk("ren", {31'b0, dmem_ren}, {31'b0, ~st});
                chk("wen", {31'b0, dmem_wen}, {31'b0, st});
                chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
                chk("mask", {28'b0, dmem_mask}, {28'b0, emask});
                if (st) chk("dmem_wdata", dmem_wdata, ewd);
                chk("ready_busy", {31'b0, ready}, 32'd0);
                chk("no_early_done", {31'b0, done}, 32'd0);
                dmem_ready = (k == delay);
                dmem_rdata = (k == delay) ? mem : 32'hDEAD_0BAD;
                if (poke && k == 0) begin
                    req = 1'b1; store = 1'b1; funct3 = 3'b010; addr = 32'h300; wdata = 32'h1111_2222;
                end else begin
                    req = 1'b0;
                end
                @(negedge clk);
            end
            dmem_ready = 1'b0;
            req = 1'b0;
        end
        chk("done_cycle", {31'b0, done}, 32'd1);
        chk("done_ren", {31'b0, dmem_ren}, 32'd0);
        chk("done_wen", {31'b0, dmem_wen}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("ready_after", {31'b0, ready}, 32'd1);
    endtask

    function automatic exp_t mk(input logic c, input logic [31:0] r, input logic m, input logic i);
        exp_t e;
        e.chk_rdata = c; e.rdata = r; e.mis = m; e.ill = i;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        dmem_rdata = 32'h0; dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_flags", {30'b0, misaligned, illegal}, 32'd0);
        chk("rst_strobes", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_mask", {28'b0, dmem_mask}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        rst = 1'b0;

        //  st    f3      addr        wdata         mem           dly mask     wdata_exp     flt  expect
        run(1'b0, 3'b010, 32'h100, 32'h0,         32'h8765_4321, 0, 4'b1111, 32'h0,         1'b0, mk(1, 32'h8765_4321, 0, 0), 1'b0);
        run(1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0,         1'b0, mk(1, 32'hFFFF_FF80, 0, 0), 1'b0);
        run(1'b0, 3'b100, 32'h103, 32'h0,         32'h80FF_0000, 1, 4'b1000, 32'h0,         1'b0, mk(1, 32'h0000_0080, 0, 0), 1'b0);
        run(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0,         3, 4'b1100, 32'hBEEF_BEEF, 1'b0, mk(0, 32'h0, 0, 0), 1'b0);
        run(1'b0, 3'b001, 32'h102, 32'h0,         32'h8001_7FFF, 0, 4'b1100, 32'h0,         1'b0, mk(1, 32'hFFFF_8001, 0, 0), 1'b0);
        run(1'b0, 3'b101, 32'h102, 32'h0,         32'h8001_7FFF, 0, 4'b1100, 32'h0,         1'b0, mk(1, 32'h0000_8001, 0, 0), 1'b0);
        run(1'b0, 3'b001, 32'h100, 32'h0,         32'h8001_7FFF, 0, 4'b0011, 32'h0,         1'b0, mk(1, 32'h0000_7FFF, 0, 0), 1'b0);
        run(1'b0, 3'b000, 32'h101, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0,         1'b0, mk(1, 32'h0000_007F, 0, 0), 1'b0);
        run(1'b1, 3'b000, 32'h201, 32'h1234_56A5, 32'h0,         0, 4'b0010, 32'hA5A5_A5A5, 1'b0, mk(0, 32'h0, 0, 0), 1'b0);
        run(1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF, 1'b0, mk(0, 32'h0, 0, 0), 1'b0);
        // Faults: no strobes, done on the second cycle.
        run(1'b0, 3'b010, 32'h101, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         1'b1, mk(0, 32'h0, 1, 0), 1'b0);
        run(1'b1, 3'b001, 32'h203, 32'h1,         32'h0,         0, 4'b0000, 32'h0,         1'b1, mk(0, 32'h0, 1, 0), 1'b0);
        run(1'b1, 3'b100, 32'h100, 32'h1,         32'h0,         0, 4'b0000, 32'h0,         1'b1, mk(0, 32'h0, 0, 1), 1'b0);
        run(1'b0, 3'b011, 32'h101, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         1'b1, mk(0, 32'h0, 0, 1), 1'b0);
        // Request pulsed mid-access must be dropped.
        run(1'b0, 3'b010, 32'h140, 32'h0,         32'h0BAD_CAFE, 2, 4'b1111, 32'h0,         1'b0, mk(1, 32'h0BAD_CAFE, 0, 0), 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_wen", {31'b0, dmem_wen}, 32'd0);
            chk("idle_ready", {31'b0, ready}, 32'd1);
        end

        // Reset while in ACCESS aborts without a completion.
        @(negedge clk);
        req = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h180; wdata = 32'h0;
        @(negedge clk);
        req = 1'b0;
        chk("abort_ren", {31'b0, dmem_ren}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_strobes", {30'b0, dmem_ren, dmem_wen}, 32'd0);
        chk("abort_no_done", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_idle_done", {31'b0, done}, 32'd0);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
